// File: rtl/outer_out_serializer.sv
// outer_out_serializer: buffers 64-bit words in a FIFO and streams them out as OUT_W-bit chunks.
// Define OUTER_OUT_SER_MSB_FIRST_EN to send the most significant chunk first (default: LSB first).
module outer_out_serializer #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in,
    input  logic             in_isReady,
    output logic             in_canReceive,
    output logic [OUT_W-1:0] out,
    output logic             out_isReady,
    input  logic             out_canReceive,
    output logic             out_isFirst,
    output logic             busy
);
    localparam int N  = 64 / OUT_W;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0]   count;
    logic [63:0]   sr, shifted;
    logic [KW-1:0] k;
    logic [6:0]    sh;
    logic          v, live, push, xfer, last, need, pop, bypass, wen;

    // live keeps in_canReceive low until the first edge after reset release
    assign in_canReceive = live & (count != (AW+1)'(DEPTH));
    assign push          = in_isReady & in_canReceive;
    assign xfer          = v & out_canReceive;
    assign last          = k == KW'(N - 1);
    assign need          = ~v | (xfer & last);
    assign pop           = need & (count != '0);
    assign bypass        = need & (count == '0) & push;
    assign wen           = push & ~bypass;

`ifdef OUTER_OUT_SER_MSB_FIRST_EN
    assign sh = 7'(64 - OUT_W) - 7'(OUT_W) * 7'(k);
`else
    assign sh = 7'(OUT_W) * 7'(k);
`endif
    assign shifted     = sr >> sh;
    assign out         = shifted[OUT_W-1:0];
    assign out_isReady = v;
    assign out_isFirst = v & (k == '0);
    assign busy        = v | (count != '0);

    always_ff @(posedge clk)
        if (wen) mem[wr] <= in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live  <= 1'b0;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            sr    <= '0;
            v     <= 1'b0;
            k     <= '0;
        end else begin
            live  <= 1'b1;
            count <= count + (AW+1)'(wen) - (AW+1)'(pop);
            if (wen) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            if (xfer) k <= last ? '0 : k + 1'b1;
            if (need) begin
                v <= pop | bypass;
                if (pop) sr <= mem[rd];
                else if (bypass) sr <= in;
            end
        end
    end
endmodule
